capture_ctrl: RTL and testbench

//  Sequences one logic-analyser capture: arms, fills the circular sample BRAM, waits for the

---
 rtl/capture_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl - sequences a single logic-analyser capture.
//
// The controller arms, fills the circular sample BRAM with the pre-trigger
// history, waits for a trigger, collects the post-trigger samples, and then
// hands the window start address and length to the UART dump engine. It
// waits for that engine to finish before it returns to idle. Sample data
// goes straight from the sampler to the BRAM. This block owns only the BRAM
// write address and the write enable.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   arm_i          start a capture (honoured only when idle)
//   abort_i        cancel a capture in progress (ignored once the dump is requested)
//   sample_valid_i sampler strobe, one new sample this cycle
//   trig_in_i      qualified trigger, one cycle wide
//   wr_en_o        BRAM write enable (combinational: sample_valid_i while capturing)
//   waddr_o        BRAM write address
//   start_dump_o   one-cycle request to the dump engine
//   dump_addr_o    first sample of the dump window, held until idle
//   dump_count_o   number of samples to dump (PRE+POST)
//   dump_busy_i    dump engine busy
//   busy_o         controller not idle
//   triggered_o    a trigger was accepted during this capture
//   done_o         one-cycle pulse when the dump has completed
module capture_ctrl #(
   parameter int AW   = 10,
   parameter int PRE  = 64,
   parameter int POST = 192
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          arm_i,
   input  logic          abort_i,
   input  logic          sample_valid_i,
   input  logic          trig_in_i,
   output logic          wr_en_o,
   output logic [AW-1:0] waddr_o,
   output logic          start_dump_o,
   output logic [AW-1:0] dump_addr_o,
   output logic [15:0]   dump_count_o,
   input  logic          dump_busy_i,
   output logic          busy_o,
   output logic          triggered_o,
   output logic          done_o
);

   localparam logic [15:0]   PRE_C  = 16'(PRE);
   localparam logic [15:0]   POST_C = 16'(POST);
   localparam logic [AW-1:0] PRE_A  = AW'(PRE);
   localparam logic [AW-1:0] ONE_A  = AW'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PREFILL  = 3'd1,
      S_ARMED    = 3'd2,
      S_POST     = 3'd3,
      S_DREQ     = 3'd4,
      S_DWAIT_HI = 3'd5,
      S_DWAIT_LO = 3'd6
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [AW-1:0] trig_addr_q, trig_addr_d;
   logic [AW-1:0] dump_addr_q, dump_addr_d;
   logic [15:0]   pre_cnt_q, pre_cnt_d;
   logic [15:0]   post_cnt_q, post_cnt_d;
   logic          start_dump_q, start_dump_d;
   logic          triggered_q, triggered_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic          capturing_s;
   logic          wr_en_s;

   // Next-state and next-register computation for the capture sequencer.
   always_comb begin
      state_d      = state_q;
      waddr_d      = waddr_q;
      trig_addr_d  = trig_addr_q;
      dump_addr_d  = dump_addr_q;
      pre_cnt_d    = pre_cnt_q;
      post_cnt_d   = post_cnt_q;
      triggered_d  = triggered_q;
      done_d       = 1'b0;
      start_dump_d = 1'b0;
      busy_d       = 1'b0;

      capturing_s = (state_q == S_PREFILL) || (state_q == S_ARMED) || (state_q == S_POST);
      wr_en_s     = sample_valid_i & capturing_s;

      // Every write advances the address. It wraps naturally at 2^AW.
      if (wr_en_s) begin
         waddr_d = waddr_q + ONE_A;
      end else begin
         waddr_d = waddr_q;
      end

      case (state_q)
         S_IDLE: begin
            if (arm_i && !abort_i) begin
               waddr_d     = '0;
               pre_cnt_d   = 16'd0;
               triggered_d = 1'b0;
               state_d     = (PRE_C == 16'd0) ? S_ARMED : S_PREFILL;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PREFILL: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (sample_valid_i) begin
               pre_cnt_d = pre_cnt_q + 16'd1;
               if (pre_cnt_d == PRE_C) begin
                  state_d = S_ARMED;
               end else begin
                  state_d = S_PREFILL;
               end
            end else begin
               state_d = S_PREFILL;
            end
         end
         S_ARMED: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (trig_in_i) begin
               // waddr_q is the slot written now, or the next one if no sample is present.
               trig_addr_d = waddr_q;
               triggered_d = 1'b1;
               post_cnt_d  = {15'd0, sample_valid_i};
               if ((POST_C == 16'd1) && sample_valid_i) begin
                  state_d = S_DREQ;
               end else begin
                  state_d = S_POST;
               end
            end else begin
               state_d = S_ARMED;
            end
         end
         S_POST: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (sample_valid_i) begin
               post_cnt_d = post_cnt_q + 16'd1;
               if (post_cnt_d == POST_C) begin
                  state_d = S_DREQ;
               end else begin
                  state_d = S_POST;
               end
            end else begin
               state_d = S_POST;
            end
         end
         S_DREQ: begin
            state_d = S_DWAIT_HI;
         end
         S_DWAIT_HI: begin
            if (dump_busy_i) begin
               state_d = S_DWAIT_LO;
            end else begin
               state_d = S_DWAIT_HI;
            end
         end
         S_DWAIT_LO: begin
            if (!dump_busy_i) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = S_DWAIT_LO;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The dump window begins PRE samples before the trigger. The subtraction wraps at AW bits.
      if (state_d == S_DREQ) begin
         start_dump_d = 1'b1;
         dump_addr_d  = trig_addr_d - PRE_A;
      end else begin
         start_dump_d = 1'b0;
         dump_addr_d  = dump_addr_q;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         waddr_q      <= '0;
         trig_addr_q  <= '0;
         dump_addr_q  <= '0;
         pre_cnt_q    <= 16'd0;
         post_cnt_q   <= 16'd0;
         start_dump_q <= 1'b0;
         triggered_q  <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         waddr_q      <= waddr_d;
         trig_addr_q  <= trig_addr_d;
         dump_addr_q  <= dump_addr_d;
         pre_cnt_q    <= pre_cnt_d;
         post_cnt_q   <= post_cnt_d;
         start_dump_q <= start_dump_d;
         triggered_q  <= triggered_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   assign wr_en_o      = wr_en_s;
   assign waddr_o      = waddr_q;
   assign start_dump_o = start_dump_q;
   assign dump_addr_o  = dump_addr_q;
   assign dump_count_o = 16'(PRE + POST);
   assign busy_o       = busy_q;
   assign triggered_o  = triggered_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Testbench for capture_ctrl. DUT "a" uses AW=4, PRE=4, POST=8.
// DUT "b" uses AW=4, PRE=0, POST=1.
// Expected write addresses and dump addresses go into queues when the
// stimulus is driven. A negedge monitor pops them when the DUT writes or
// requests a dump.
module tb_capture_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       arm, abort, sv, trig, dbusy;
   logic       wr_en, start_dump, busy, triggered, done;
   logic [3:0] waddr, dump_addr;
   logic [15:0] dump_count;

   logic       b_arm, b_abort, b_sv, b_trig, b_dbusy;
   logic       b_wr_en, b_start, b_busy, b_triggered, b_done;
   logic [3:0] b_waddr, b_dump_addr;
   logic [15:0] b_dump_count;

   int total = 0;
   int bad   = 0;
   int sd_cnt = 0;
   int done_cnt = 0;
   logic [3:0] wq[$];
   logic [3:0] dq[$];
   logic [3:0] mon_exp;

   always #5 clk = ~clk;

   capture_ctrl #(.AW(4), .PRE(4), .POST(8)) u_a (
      .clk(clk), .rst_n(rst_n), .arm_i(arm), .abort_i(abort),
      .sample_valid_i(sv), .trig_in_i(trig), .wr_en_o(wr_en), .waddr_o(waddr),
      .start_dump_o(start_dump), .dump_addr_o(dump_addr), .dump_count_o(dump_count),
      .dump_busy_i(dbusy), .busy_o(busy), .triggered_o(triggered), .done_o(done)
   );

   capture_ctrl #(.AW(4), .PRE(0), .POST(1)) u_b (
      .clk(clk), .rst_n(rst_n), .arm_i(b_arm), .abort_i(b_abort),
      .sample_valid_i(b_sv), .trig_in_i(b_trig), .wr_en_o(b_wr_en), .waddr_o(b_waddr),
      .start_dump_o(b_start), .dump_addr_o(b_dump_addr), .dump_count_o(b_dump_count),
      .dump_busy_i(b_dbusy), .busy_o(b_busy), .triggered_o(b_triggered), .done_o(b_done)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Scoreboard monitor for DUT a: writes and dump requests
   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en) begin
            if (wq.size() == 0) begin
               check_val("wr_unexpected", 32'(waddr), 32'hFFFF_FFFF);
            end else begin
               mon_exp = wq.pop_front();
               check_val("waddr", 32'(waddr), 32'(mon_exp));
            end
         end
         if (start_dump) begin
            sd_cnt++;
            if (dq.size() == 0) begin
               check_val("sd_unexpected", 32'(dump_addr), 32'hFFFF_FFFF);
            end else begin
               mon_exp = dq.pop_front();
               check_val("dump_addr", 32'(dump_addr), 32'(mon_exp));
               check_val("dump_count", 32'(dump_count), 32'd12);
            end
         end
         if (done) done_cnt++;
      end
   end

   task automatic step(input logic a, input logic ab, input logic s, input logic t, input logic db);
      @(posedge clk); #1;
      arm = a; abort = ab; sv = s; trig = t; dbusy = db;
      @(negedge clk); #1;
   endtask

   task automatic stepb(input logic a, input logic s, input logic t, input logic db);
      @(posedge clk); #1;
      b_arm = a; b_sv = s; b_trig = t; b_dbusy = db;
      @(negedge clk); #1;
   endtask

   // Starts with the DREQ cycle, then runs the busy handshake and checks for a single done pulse
   task automatic finish_dump(input int lo, input int hi, input logic ab_lo);
      int sd0;
      int dn0;
      sd0 = sd_cnt;
      dn0 = done_cnt;
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_val("sd_latency", 32'(start_dump), 32'd1);
      for (int i = 0; i < lo; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         check_val("dwait_hi_busy", 32'(busy), 32'd1);
         check_val("sd_one_cycle", 32'(start_dump), 32'd0);
      end
      for (int i = 0; i < hi; i++) begin
         step(1'b0, (i > 0) ? ab_lo : 1'b0, 1'b0, 1'b0, 1'b1);
         check_val("dwait_lo_busy", 32'(busy), 32'd1);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("no_early_done", 32'(done), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("done_pulse", 32'(done), 32'd1);
      check_val("idle_after_dump", 32'(busy), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("done_drop", 32'(done), 32'd0);
      check_val("sd_count", 32'(sd_cnt - sd0), 32'd1);
      check_val("done_count", 32'(done_cnt - dn0), 32'd1);
      check_val("wq_drained", 32'(wq.size()), 32'd0);
      check_val("dq_drained", 32'(dq.size()), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      arm = 1'b0; abort = 1'b0; sv = 1'b0; trig = 1'b0; dbusy = 1'b0;
      b_arm = 1'b0; b_abort = 1'b0; b_sv = 1'b0; b_trig = 1'b0; b_dbusy = 1'b0;
      #12;
      check_val("rst_waddr", 32'(waddr), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_sd", 32'(start_dump), 32'd0);
      check_val("rst_trig", 32'(triggered), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_wren", 32'(wr_en), 32'd0);
      check_val("rst_daddr", 32'(dump_addr), 32'd0);
      check_val("rst_dcount", 32'(dump_count), 32'd12);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: basic capture, trigger on the 11th sample, slow handshake with abort in DWAIT_LO
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 18; k++) begin
         if (k == 10) dq.push_back(4'd6);
         wq.push_back(4'(k));
         step(1'b0, 1'b0, 1'b1, (k == 10), 1'b0);
         if (k == 0) check_val("t1_busy", 32'(busy), 32'd1);
      end
      check_val("t1_triggered", 32'(triggered), 32'd1);
      finish_dump(3, 20, 1'b1);

      // 2: trigger during prefill is ignored, arm during POST is ignored
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 13; k++) begin
         if (k == 5) dq.push_back(4'd1);
         wq.push_back(4'(k));
         step((k == 7), 1'b0, 1'b1, (k == 2 || k == 5), 1'b0);
         if (k == 3) check_val("t2_pre_trig_ign", 32'(triggered), 32'd0);
      end
      finish_dump(1, 2, 1'b0);

      // 3: wrap, trigger without a sample at waddr=2
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 18; k++) begin
         wq.push_back(4'(k));
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      dq.push_back(4'd14);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         wq.push_back(4'(2 + k));
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      finish_dump(0, 1, 1'b0);

      // 4: abort in POST, abort beats arm, re-arm restarts at 0
      begin
         int sd0;
         sd0 = sd_cnt;
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         for (int k = 0; k < 7; k++) begin
            wq.push_back(4'(k));
            step(1'b0, 1'b0, 1'b1, (k == 4), 1'b0);
         end
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         check_val("t4_abort_idle", 32'(busy), 32'd0);
         check_val("t4_trig_hold", 32'(triggered), 32'd1);
         check_val("t4_idle_wren", 32'(wr_en), 32'd0);
         step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         check_val("t4_abort_beats_arm", 32'(busy), 32'd0);
         check_val("t4_no_sd", 32'(sd_cnt - sd0), 32'd0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 12; k++) begin
         if (k == 4) dq.push_back(4'd0);
         wq.push_back(4'(k));
         step(1'b0, 1'b0, 1'b1, (k == 4), 1'b0);
         if (k == 0) check_val("t4_arm_clr_trig", 32'(triggered), 32'd0);
      end
      finish_dump(0, 1, 1'b0);

      // 6a: asynchronous reset in the middle of POST
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         if (k == 4) dq.push_back(4'd0);
         wq.push_back(4'(k));
         step(1'b0, 1'b0, 1'b1, (k == 4), 1'b0);
      end
      #2 rst_n = 1'b0;
      #1;
      check_val("t6_rst_waddr", 32'(waddr), 32'd0);
      check_val("t6_rst_busy", 32'(busy), 32'd0);
      check_val("t6_rst_trig", 32'(triggered), 32'd0);
      check_val("t6_rst_wren", 32'(wr_en), 32'd0);
      check_val("t6_rst_sd", 32'(start_dump), 32'd0);
      wq.delete();
      dq.delete();
      sv = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // 6b: PRE=0, POST=1, trigger with a sample goes straight to the dump request
      stepb(1'b1, 1'b0, 1'b0, 1'b0);
      stepb(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("b_wren0", 32'(b_wr_en), 32'd1);
      check_val("b_waddr0", 32'(b_waddr), 32'd0);
      stepb(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("b_waddr1", 32'(b_waddr), 32'd1);
      stepb(1'b0, 1'b1, 1'b1, 1'b0);
      check_val("b_wren_trig", 32'(b_wr_en), 32'd1);
      check_val("b_waddr_trig", 32'(b_waddr), 32'd2);
      stepb(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("b_sd", 32'(b_start), 32'd1);
      check_val("b_dump_addr", 32'(b_dump_addr), 32'd2);
      check_val("b_dump_count", 32'(b_dump_count), 32'd1);
      check_val("b_triggered", 32'(b_triggered), 32'd1);
      check_val("b_dreq_wren", 32'(b_wr_en), 32'd0);
      stepb(1'b0, 1'b0, 1'b0, 1'b1);
      check_val("b_sd_drop", 32'(b_start), 32'd0);
      stepb(1'b0, 1'b0, 1'b0, 1'b0);
      stepb(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("b_done", 32'(b_done), 32'd1);
      check_val("b_idle", 32'(b_busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
